// File: rtl/reset_sequencer.sv
// Reset sequencer: merges power-on, button, software and watchdog reset sources, holds all
// domain resets for CYCLES edges, then releases them one by one in ascending order, STAGGER
// edges apart. The cause of the last reset is kept for firmware readback.
module reset_sequencer #(
  parameter int unsigned CYCLES          = 20,
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned STAGGER         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WATCHDOG_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_i,
  input  logic                sw_reset_i,
  input  logic                wdt_kick_i,
  output logic [CHANNELS-1:0] reset_o,
  output logic                busy_o,
  output logic [1:0]          cause_o
);

  localparam int unsigned HoldW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned StgW  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(CYCLES - 1);
  localparam logic [StgW-1:0]  StgLast  = StgW'(STAGGER - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CauseBtn = 2'd1;
  localparam logic [1:0] CauseSw  = 2'd2;
  localparam logic [1:0] CauseWdt = 2'd3;

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [StgW-1:0]     stg_q, stg_d;
  logic [CHANNELS-1:0] rst_q, rst_d, rst_shift;
  logic [1:0]          cause_q, cause_d;
  logic                sync1_q, sync2_q;
  logic [DebW-1:0]     deb_q, deb_d;
  logic                btn_press;
  logic                wdt_fire;
  logic                trigger;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counter: counts synchronised-high cycles, saturating at the press threshold
  always_comb begin
    deb_d = deb_q;
    if (!sync2_q) begin
      deb_d = '0;
    end else if (deb_q != DebLast) begin
      deb_d = deb_q + 1'b1;
    end
  end

  // Debounce counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

  assign btn_press = sync2_q && (deb_q == DebLast);

  if (WATCHDOG_CYCLES > 0) begin : g_wdt
    localparam int unsigned WdtW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WdtW-1:0] WdtLast = WdtW'(WATCHDOG_CYCLES - 1);

    logic [WdtW-1:0] wdt_q, wdt_d;

    // Watchdog counts only in RUN; a kick in the timeout cycle suppresses the fire
    always_comb begin
      wdt_fire = (state_q == StRun) && !wdt_kick_i && (wdt_q == WdtLast);
      wdt_d    = wdt_q + 1'b1;
      if ((state_q != StRun) || wdt_kick_i || wdt_fire) begin
        wdt_d = '0;
      end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_d;
      end
    end
  end else begin : g_no_wdt
    logic unused_kick;
    assign unused_kick = wdt_kick_i;
    assign wdt_fire    = 1'b0;
  end

  // Each release step clears the lowest still-asserted channel
  assign rst_shift = rst_q << 1;

  // Sequencer next-state: hold, staggered release, run; any trigger outside HOLD restarts
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    trigger = btn_press || wdt_fire || sw_reset_i;
    case (state_q)
      StHold: begin
        if (btn_press) begin
          hold_d = '0;
        end else if (hold_q == HoldLast) begin
          hold_d  = '0;
          stg_d   = '0;
          rst_d   = rst_shift;
          state_d = (rst_shift == '0) ? StRun : StRelease;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRelease: begin
        if (stg_q == StgLast) begin
          stg_d = '0;
          rst_d = rst_shift;
          if (rst_shift == '0) begin
            state_d = StRun;
          end
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      StRun: begin
        rst_d = '0;
      end
      default: begin
        state_d = StHold;
        rst_d   = '1;
      end
    endcase
    if ((state_q != StHold) && trigger) begin
      state_d = StHold;
      hold_d  = '0;
      stg_d   = '0;
      rst_d   = '1;
      cause_d = btn_press ? CauseBtn : (wdt_fire ? CauseWdt : CauseSw);
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHold;
      hold_q  <= '0;
      stg_q   <= '0;
      rst_q   <= '1;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
    end
  end

  assign reset_o = rst_q;
  assign busy_o  = |rst_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (2-channel with watchdog, 4-channel without),
// a directed vector table, hand-written async-reset sequences and random stimulus checked
// against a behavioural model derived from elapsed-edge arithmetic.
module tb_reset_sequencer;

  localparam int unsigned A_CYC = 20, A_CH = 2, A_STG = 4, A_DEB = 16, A_WDT = 100;
  localparam int unsigned B_CYC = 20, B_CH = 4, B_STG = 2, B_DEB = 3,  B_WDT = 0;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, btn_a = 1'b0, sw_a = 1'b0, kick_a = 1'b1;
  logic       rst_b = 1'b1, btn_b = 1'b0, sw_b = 1'b0, kick_b = 1'b0;
  logic [1:0] out_a;
  logic [3:0] out_b;
  logic       busy_a, busy_b;
  logic [1:0] cause_a, cause_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .CYCLES(A_CYC), .CHANNELS(A_CH), .STAGGER(A_STG), .DEBOUNCE_CYCLES(A_DEB),
    .WATCHDOG_CYCLES(A_WDT)
  ) dut_a (
    .clk(clk), .reset(rst_a), .btn_i(btn_a), .sw_reset_i(sw_a), .wdt_kick_i(kick_a),
    .reset_o(out_a), .busy_o(busy_a), .cause_o(cause_a)
  );

  reset_sequencer #(
    .CYCLES(B_CYC), .CHANNELS(B_CH), .STAGGER(B_STG), .DEBOUNCE_CYCLES(B_DEB),
    .WATCHDOG_CYCLES(B_WDT)
  ) dut_b (
    .clk(clk), .reset(rst_b), .btn_i(btn_b), .sw_reset_i(sw_b), .wdt_kick_i(kick_b),
    .reset_o(out_b), .busy_o(busy_b), .cause_o(cause_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Outputs are derived from elapsed edges since the hold ended: channel k is released once
  // rel >= STAGGER*k; the run phase is when every channel has been released.
  typedef struct packed {
    int s1; int s2; int deb; int hold; int rel; int wdt; int cause; bit inhold;
  } mdl_t;

  function automatic int p_cyc(input int i); return (i == 0) ? A_CYC : B_CYC; endfunction
  function automatic int p_ch(input int i);  return (i == 0) ? A_CH  : B_CH;  endfunction
  function automatic int p_stg(input int i); return (i == 0) ? A_STG : B_STG; endfunction
  function automatic int p_deb(input int i); return (i == 0) ? A_DEB : B_DEB; endfunction
  function automatic int p_wdt(input int i); return (i == 0) ? A_WDT : B_WDT; endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.inhold = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] mdl_rst(input int i, input mdl_t m);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < p_ch(i); k++) r[k] = m.inhold || (m.rel < p_stg(i) * k);
    return r;
  endfunction

  function automatic bit mdl_run(input int i, input mdl_t m);
    return !m.inhold && (m.rel >= p_stg(i) * (p_ch(i) - 1));
  endfunction

  function automatic mdl_t mdl_next(input int i, input mdl_t m, input logic btn,
                                    input logic sw, input logic kick);
    mdl_t n;
    bit   press, run, fire;
    int   deb_max;
    n       = m;
    deb_max = p_deb(i) - 1;
    press   = (m.s2 != 0) && (m.deb == deb_max);
    run     = mdl_run(i, m);
    fire    = (p_wdt(i) > 0) && run && !kick && (m.wdt == p_wdt(i) - 1);
    if (!m.inhold && (press || sw || fire)) begin
      n.inhold = 1'b1;
      n.hold   = 0;
      n.cause  = press ? 1 : (fire ? 3 : 2);
    end else if (m.inhold) begin
      if (press) n.hold = 0;
      else if (m.hold == p_cyc(i) - 1) begin
        n.inhold = 1'b0;
        n.rel    = 0;
      end else n.hold = m.hold + 1;
    end else if (m.rel < 100000) begin
      n.rel = m.rel + 1;
    end
    n.wdt = (run && !kick && !fire) ? m.wdt + 1 : 0;
    n.deb = (m.s2 == 0) ? 0 : ((m.deb == deb_max) ? deb_max : m.deb + 1);
    n.s2  = m.s1;
    n.s1  = int'(btn);
    return n;
  endfunction

  mdl_t mdl_a, mdl_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) mdl_a <= mdl_reset();
    else       mdl_a <= mdl_next(0, mdl_a, btn_a, sw_a, kick_a);
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) mdl_b <= mdl_reset();
    else       mdl_b <= mdl_next(1, mdl_b, btn_b, sw_b, kick_b);
  end

  always @(negedge clk) begin
    chk("model_a_reset_o", 32'(out_a), 32'(mdl_rst(0, mdl_a)));
    chk("model_a_busy", 32'(busy_a), 32'(|mdl_rst(0, mdl_a)));
    chk("model_a_cause", 32'(cause_a), 32'(mdl_a.cause));
    chk("model_b_reset_o", 32'(out_b), 32'(mdl_rst(1, mdl_b)));
    chk("model_b_busy", 32'(busy_b), 32'(|mdl_rst(1, mdl_b)));
    chk("model_b_cause", 32'(cause_b), 32'(mdl_b.cause));
  end

  // ---------------- directed vector table for instance A ----------------
  typedef struct {
    logic rst; logic btn; logic sw; logic kick; int n;
    logic [1:0] rst_o; logic busy; logic [1:0] cause; string name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic btn, input logic sw, input logic kick,
                             input int n, input logic [1:0] rst_o, input logic busy,
                             input logic [1:0] cause, input string name);
    vec_t t;
    t.rst = rst; t.btn = btn; t.sw = sw; t.kick = kick; t.n = n;
    t.rst_o = rst_o; t.busy = busy; t.cause = cause; t.name = name;
    return t;
  endfunction

  // Expected 4-channel pattern e edges after reset release: all held for 20 edges, then one
  // channel per 2 edges.
  function automatic logic [3:0] b_exp(input int e);
    logic [3:0] f;
    f = 4'hF;
    if (e < 20) return f;
    return f << ((e - 20) / 2 + 1);
  endfunction

  task automatic b_release_check(input string tag, input logic [1:0] cause);
    logic [3:0] e_o;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk);
      @(negedge clk);
      e_o = b_exp(e);
      chk({tag, "_reset_o"}, 32'(out_b), 32'(e_o));
      chk({tag, "_busy"}, 32'(busy_b), 32'(e_o != 4'h0));
    end
    chk({tag, "_cause"}, 32'(cause_b), 32'(cause));
    #1;
  endtask

  initial begin
    tbl.push_back(v(1, 0, 0, 1,  3, 2'b11, 1, 0, "por_held"));
    tbl.push_back(v(0, 0, 0, 1, 19, 2'b11, 1, 0, "por_hold19"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b10, 1, 0, "por_rel0"));
    tbl.push_back(v(0, 0, 0, 1,  3, 2'b10, 1, 0, "por_stagger"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b00, 0, 0, "por_run"));
    tbl.push_back(v(0, 0, 0, 1, 10, 2'b00, 0, 0, "run_stay"));
    tbl.push_back(v(0, 0, 1, 1,  1, 2'b11, 1, 2, "sw_trig"));
    tbl.push_back(v(0, 0, 0, 1, 19, 2'b11, 1, 2, "sw_hold19"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b10, 1, 2, "sw_rel0"));
    tbl.push_back(v(0, 0, 0, 1,  3, 2'b10, 1, 2, "sw_stagger"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b00, 0, 2, "sw_run"));
    tbl.push_back(v(0, 1, 0, 1, 10, 2'b00, 0, 2, "btn_short"));
    tbl.push_back(v(0, 0, 0, 1, 20, 2'b00, 0, 2, "btn_short_gone"));
    tbl.push_back(v(0, 1, 0, 1, 17, 2'b00, 0, 2, "btn_pre_press"));
    tbl.push_back(v(0, 1, 0, 1,  1, 2'b11, 1, 1, "btn_trig"));
    tbl.push_back(v(0, 1, 0, 1, 22, 2'b11, 1, 1, "btn_held"));
    tbl.push_back(v(0, 0, 0, 1, 21, 2'b11, 1, 1, "btn_drop_hold"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b10, 1, 1, "btn_rel0"));
    tbl.push_back(v(0, 0, 0, 1,  4, 2'b00, 0, 1, "btn_run"));
    tbl.push_back(v(0, 0, 0, 0, 49, 2'b00, 0, 1, "wdt_gap1"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b00, 0, 1, "wdt_kick1"));
    tbl.push_back(v(0, 0, 0, 0, 49, 2'b00, 0, 1, "wdt_gap2"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b00, 0, 1, "wdt_kick2"));
    tbl.push_back(v(0, 0, 0, 0, 99, 2'b00, 0, 1, "wdt_edge99"));
    tbl.push_back(v(0, 0, 0, 0,  1, 2'b11, 1, 3, "wdt_fire"));
    tbl.push_back(v(0, 0, 0, 1, 24, 2'b00, 0, 3, "wdt_rerun"));
    tbl.push_back(v(0, 0, 0, 0, 82, 2'b00, 0, 3, "all3_wdt_wait"));
    tbl.push_back(v(0, 1, 0, 0, 17, 2'b00, 0, 3, "all3_btn_wait"));
    tbl.push_back(v(0, 1, 1, 0,  1, 2'b11, 1, 1, "all3_trig"));
    tbl.push_back(v(0, 0, 0, 1, 21, 2'b11, 1, 1, "all3_hold"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b10, 1, 1, "all3_rel0"));
    tbl.push_back(v(0, 0, 1, 1,  1, 2'b11, 1, 2, "sw_in_release"));
    tbl.push_back(v(0, 0, 0, 1, 19, 2'b11, 1, 2, "restart_hold19"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b10, 1, 2, "restart_rel0"));
    tbl.push_back(v(0, 0, 0, 1,  3, 2'b10, 1, 2, "restart_stagger"));
    tbl.push_back(v(0, 0, 0, 1,  1, 2'b00, 0, 2, "restart_run"));

    foreach (tbl[j]) begin
      rst_a  = tbl[j].rst;
      btn_a  = tbl[j].btn;
      sw_a   = tbl[j].sw;
      kick_a = tbl[j].kick;
      repeat (tbl[j].n) @(posedge clk);
      @(negedge clk);
      chk({tbl[j].name, "_reset_o"}, 32'(out_a), 32'(tbl[j].rst_o));
      chk({tbl[j].name, "_busy"}, 32'(busy_a), 32'(tbl[j].busy));
      chk({tbl[j].name, "_cause"}, 32'(cause_a), 32'(tbl[j].cause));
      #1;
    end
    sw_a   = 1'b0;
    kick_a = 1'b1;

    // Instance B: release, software restart, then async reset in the middle of RELEASE
    rst_b = 1'b0;
    b_release_check("b_por", 2'd0);
    sw_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_sw_trig_reset_o", 32'(out_b), 32'h0000_000F);
    chk("b_sw_trig_cause", 32'(cause_b), 32'd2);
    #1;
    sw_b = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("b_mid_release", 32'(out_b), 32'h0000_000E);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_async_imm_reset_o", 32'(out_b), 32'h0000_000F);
    chk("b_async_imm_busy", 32'(busy_b), 32'd1);
    chk("b_async_imm_cause", 32'(cause_b), 32'd0);
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    b_release_check("b_after_async", 2'd0);

    // Random stimulus on both instances, checked by the model every cycle
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) btn_a = ~btn_a;
      if ($urandom_range(0, 19) == 0) btn_b = ~btn_b;
      sw_a   = ($urandom_range(0, 59) == 0);
      sw_b   = ($urandom_range(0, 59) == 0);
      kick_a = ($urandom_range(0, 79) == 0);
      kick_b = ($urandom_range(0, 9) == 0);
      rst_a  = ($urandom_range(0, 399) == 0);
      rst_b  = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      #1;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output boot reset generator used by the FPGA top levels.
- Merges four reset sources: power-on/async reset, a debounced board button, a software request and a watchdog.
- Produces CHANNELS staggered, synchronously released active-high reset outputs for the SOC domains (core, peripherals, UART, GPIO).
- Records the cause of the last reset for firmware readback.

Parameters:
- CYCLES, 20, clock edges all outputs stay asserted in HOLD (min 1)
- CHANNELS, 2, number of reset outputs (1..8)
- STAGGER, 4, clock edges between consecutive channel releases (min 1)
- DEBOUNCE_CYCLES, 16, consecutive synchronised-high cycles before the button counts as pressed (min 1)
- WATCHDOG_CYCLES, 0, watchdog timeout in cycles; 0 disables the watchdog

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset (power-on / PLL not locked)
- btn_i  input  1  raw board reset button, active-high, asynchronous to clk
- sw_reset_i  input  1  one-cycle software reset request from the CPU
- wdt_kick_i  input  1  watchdog restart pulse
- reset_o  output  CHANNELS  per-domain reset, active-high; bit 0 is released first
- busy_o  output  1  high while any reset_o bit is asserted
- cause_o  output  2  last reset cause: 0 POR, 1 button, 2 software, 3 watchdog

Behaviour:
- Async reset asserted: state HOLD, hold counter 0, stagger counter 0, reset_o all ones, busy_o 1, cause_o 0.
- Async reset also clears the button synchroniser, the debounce counter and the watchdog counter.
- Outputs are registered only; there is no combinational path from any input to reset_o.
- Button path: 2-flop synchroniser, then a debounce counter.
  - Counter increments while the synchronised button is high and clears to 0 when it is low.
  - btn_press is true when the counter reaches DEBOUNCE_CYCLES-1 with the input still high; the counter saturates there.
- Watchdog (only when WATCHDOG_CYCLES>0): counts only in RUN.
  - Cleared by wdt_kick_i or on leaving RUN.
  - wdt_fire when the count reaches WATCHDOG_CYCLES-1 without a kick.
  - A kick in that same cycle wins; no fire.
- States:
  - HOLD: reset_o all ones.
    - Hold counter counts 0..CYCLES-1; reaching CYCLES-1 moves to RELEASE.
    - The counter reloads to 0 while btn_press is true, so a held button extends HOLD.
    - sw_reset_i and wdt_kick_i are ignored in HOLD.
  - RELEASE: channel k clears on the edge that occurs STAGGER*k edges after HOLD exits.
    - reset_o[0] clears on the same edge HOLD exits.
    - Released bits stay low; order is strictly ascending.
    - When bit CHANNELS-1 clears, move to RUN and drop busy_o on the same edge.
    - CHANNELS=1: HOLD goes directly to RUN.
  - RUN: reset_o all zero, busy_o 0.
- Triggers in RELEASE or RUN: btn_press, sw_reset_i or wdt_fire.
  - On the next edge: all reset_o bits reassert, go to HOLD, clear the counters, update cause_o.
- Simultaneous triggers: priority button > watchdog > software.
  - cause_o records only the winning cause.
- A trigger during RELEASE restarts from HOLD; partially released channels reassert.
- cause_o keeps its value until the next trigger or async reset.
- Latency from reset deassertion to reset_o[0]=0 is CYCLES edges; to RUN it is CYCLES+STAGGER*(CHANNELS-1) edges.

Test Plan:
- Defaults, reset held 3 cycles then released -> reset_o=2'b11 for 20 edges, then 2'b10, 4 edges later 2'b00 with busy_o=0, cause_o=0.
- In RUN, pulse sw_reset_i 1 cycle -> next edge reset_o=2'b11, cause_o=2; release repeats the 20+4 timing.
- In RUN, btn_i high 10 cycles then low -> no reset. Next, btn_i high 40 cycles -> reset after 2+16 cycles, cause_o=1; HOLD lasts until 20 cycles after the debounced button drops.
- WATCHDOG_CYCLES=100, kick every 50 cycles -> no reset. Stop kicking -> reset exactly 100 cycles after the last kick, cause_o=3.
- Same cycle: btn_press, sw_reset_i and wdt_fire -> cause_o=1. Assert sw_reset_i during RELEASE after reset_o[0] cleared -> reset_o returns to all ones, full sequence restarts.
- CHANNELS=4, STAGGER=2, async reset pulsed mid-RELEASE -> immediate all-ones outputs, cause_o=0, releases at edges 20/22/24/26.
